// File: rtl/argmax_if.sv
// Result channel of the argmax classifier: winning class index and its value on a
// valid/ready handshake toward the PS readback logic.
interface argmax_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 4
);
   logic [IDX_W-1:0]  class_tdata;
   logic [DATA_W-1:0] max_tdata;
   logic              class_tvalid;
   logic              class_tready;

   modport master (
      output class_tdata,
      output max_tdata,
      output class_tvalid,
      input  class_tready
   );

   modport slave (
      input  class_tdata,
      input  max_tdata,
      input  class_tvalid,
      output class_tready
   );
endinterface

// File: rtl/argmax_classifier.sv
// Output-layer collector: latches each perceptron result on its done, then scans the
// captured values serially for the signed maximum and offers the winner on out_if.
module argmax_classifier #(
   parameter int N_NEURONS = 10,
   parameter int DATA_W    = 32,
   parameter int IDX_W     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_NEURONS*DATA_W-1:0] a_tdata_flat,
   input  logic [N_NEURONS-1:0]        done_vec,
   argmax_if.master                    out_if,
   output logic                        busy
);
   typedef enum logic [1:0] {IDLE, COLLECT, SCAN, OUT} state_t;

   state_t               state_q, state_d;
   logic                 start_q, start_d;
   logic                 start_e;
   logic [N_NEURONS-1:0] armed_q, armed_d;
   logic [N_NEURONS-1:0] captured_q, captured_d;
   logic [N_NEURONS-1:0] arm_set, cap_set;
   logic [DATA_W-1:0]    cap_buf_q [N_NEURONS];
   logic [DATA_W-1:0]    cap_buf_d [N_NEURONS];
   logic [DATA_W-1:0]    scan_val;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     best_idx_q, best_idx_d;
   logic [DATA_W-1:0]    best_q, best_d;
   logic [IDX_W-1:0]     class_q, class_d;
   logic [DATA_W-1:0]    max_q, max_d;
   logic                 tvalid_q, tvalid_d;
   logic                 busy_q, busy_d;

   assign start_e = start & ~start_q;

   // A neuron only captures after it has been seen low in this inference, so a done
   // left high from the previous run cannot leak a stale value in.
   generate
      for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
         assign arm_set[gi]   = (state_q == COLLECT) & ~done_vec[gi];
         assign cap_set[gi]   = (state_q == COLLECT) & armed_q[gi] & done_vec[gi] & ~captured_q[gi];
         assign cap_buf_d[gi] = cap_set[gi] ? a_tdata_flat[gi*DATA_W +: DATA_W] : cap_buf_q[gi];

         always_ff @(posedge clk) begin
            cap_buf_q[gi] <= cap_buf_d[gi];
         end
      end
   endgenerate

   assign scan_val = cap_buf_q[idx_q];

   always_comb begin
      start_d    = start;
      state_d    = state_q;
      armed_d    = armed_q | arm_set;
      captured_d = captured_q | cap_set;
      idx_d      = idx_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      class_d    = class_q;
      max_d      = max_q;
      tvalid_d   = tvalid_q;

      case (state_q)
         COLLECT: begin
            if (&captured_d) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            // Strict greater-than keeps the lowest index on ties.
            if ((idx_q == '0) || ($signed(scan_val) > $signed(best_q))) begin
               best_d     = scan_val;
               best_idx_d = idx_q;
            end
            if (idx_q == IDX_W'(N_NEURONS - 1)) begin
               state_d  = OUT;
               class_d  = best_idx_d;
               max_d    = best_d;
               tvalid_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         OUT: begin
            if (tvalid_q && out_if.class_tready) begin
               tvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: ;
      endcase

      // A new inference aborts whatever is in flight; a handshake on this same edge
      // still completes because tvalid was already presented.
      if (start_e) begin
         tvalid_d   = 1'b0;
         armed_d    = '0;
         captured_d = '0;
         state_d    = COLLECT;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         armed_q    <= '0;
         captured_q <= '0;
         idx_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         class_q    <= '0;
         max_q      <= '0;
         tvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         armed_q    <= armed_d;
         captured_q <= captured_d;
         idx_q      <= idx_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         class_q    <= class_d;
         max_q      <= max_d;
         tvalid_q   <= tvalid_d;
         busy_q     <= busy_d;
      end
   end

   assign out_if.class_tdata  = class_q;
   assign out_if.max_tdata    = max_q;
   assign out_if.class_tvalid = tvalid_q;
   assign busy                = busy_q;
endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: expected results go into a scoreboard queue,
// and a negedge monitor pops and compares on every output handshake.
module tb_argmax_classifier;
   localparam int N  = 10;
   localparam int DW = 32;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [N*DW-1:0] a_tdata_flat;
   logic [N-1:0]    done_vec;
   logic            busy;

   argmax_if #(.DATA_W(DW), .IDX_W(IW)) out_if ();

   argmax_classifier #(.N_NEURONS(N), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a_tdata_flat (a_tdata_flat),
      .done_vec     (done_vec),
      .out_if       (out_if),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] cls;
      logic [DW-1:0] mx;
      string         name;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] vals [N];
   int            vectors    = 0;
   int            miscompares = 0;
   int            pushes     = 0;
   int            pops       = 0;
   int            bad_cycles;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Monitor: every accepted output must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && out_if.class_tvalid && out_if.class_tready) begin
         pops++;
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got class %0d max 0x%0h, expected no output",
                     out_if.class_tdata, out_if.max_tdata);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_class"}, 64'(out_if.class_tdata), 64'(mon_e.cls));
            check({mon_e.name, "_max"},   64'(out_if.max_tdata),   64'(mon_e.mx));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vals();
      for (int i = 0; i < N; i++) a_tdata_flat[i*DW +: DW] = vals[i];
   endtask

   task automatic expect_result(input logic [IW-1:0] cls, input logic [DW-1:0] mx, input string name);
      exp_t e;
      e.cls  = cls;
      e.mx   = mx;
      e.name = name;
      sb.push_back(e);
      pushes++;
   endtask

   // Rising start, then one COLLECT cycle so neurons with done low get armed.
   task automatic begin_inf();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   // Called just after the capture edge E0; tvalid must first be seen after E0+10.
   task automatic wait_result(input string name);
      int lat;
      @(negedge clk);
      lat = 0;
      while (!out_if.class_tvalid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'(10));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      done_vec = '0;
      a_tdata_flat = '0;
      out_if.class_tready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_tvalid", 64'(out_if.class_tvalid), 64'(0));
      check("reset_class",  64'(out_if.class_tdata),  64'(0));
      check("reset_max",    64'(out_if.max_tdata),    64'(0));
      check("reset_busy",   64'(busy),                64'(0));

      // 1: distinct maximum at neuron 7
      for (int i = 0; i < N; i++) vals[i] = 32'(i) * 32'h0100_0000;
      vals[7] = 32'h0C00_0000;
      expect_result(4'd7, 32'h0C00_0000, "t1");
      begin_inf();
      set_vals();
      done_vec = '1;
      tick();
      wait_result("t1");
      tick();
      check("t1_busy_after", 64'(busy), 64'(0));
      done_vec = '0;

      // 2: tie between neurons 2 and 5, lowest index wins
      for (int i = 0; i < N; i++) vals[i] = 32'(i) * 32'h0010_0000;
      vals[2] = 32'h0500_0000;
      vals[5] = 32'h0500_0000;
      expect_result(4'd2, 32'h0500_0000, "t2");
      begin_inf();
      set_vals();
      done_vec = '1;
      tick();
      wait_result("t2");
      tick();
      done_vec = '0;

      // 3: all negative, including the most negative value
      for (int i = 0; i < N; i++) vals[i] = 32'(-(i + 5));
      vals[9] = 32'h8000_0000;
      expect_result(4'd0, 32'hFFFF_FFFB, "t3");
      begin_inf();
      set_vals();
      done_vec = '1;
      tick();
      wait_result("t3");
      tick();

      // 4: stale done held across start, then staggered reverse-order rises
      for (int i = 0; i < N; i++) vals[i] = 32'h7000_0000;
      set_vals();
      begin_inf();
      tick();
      tick();
      check("t4_no_early_valid", 64'(out_if.class_tvalid), 64'(0));
      check("t4_busy_collect",   64'(busy),                64'(1));
      done_vec = '0;
      tick();
      for (int i = 0; i < N; i++) vals[i] = 32'(i * 16);
      vals[4] = 32'd1000;
      set_vals();
      expect_result(4'd4, 32'd1000, "t4");
      for (int k = N - 1; k >= 0; k--) begin
         done_vec[k] = 1'b1;
         tick();
      end
      wait_result("t4");
      tick();
      done_vec = '0;

      // 5: backpressure holds the result stable
      for (int i = 0; i < N; i++) vals[i] = 32'(i * 3);
      vals[6] = 32'd500;
      expect_result(4'd6, 32'd500, "t5");
      out_if.class_tready = 1'b0;
      begin_inf();
      set_vals();
      done_vec = '1;
      tick();
      wait_result("t5");
      bad_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (!out_if.class_tvalid || out_if.class_tdata != 4'd6 || out_if.max_tdata != 32'd500)
            bad_cycles++;
      end
      check("t5_hold_bad_cycles", 64'(bad_cycles), 64'(0));
      out_if.class_tready = 1'b1;
      tick();
      check("t5_tvalid_after", 64'(out_if.class_tvalid), 64'(0));
      check("t5_busy_after",   64'(busy),                64'(0));
      done_vec = '0;

      // 6a: abort mid-SCAN, then re-armed collection
      for (int i = 0; i < N; i++) vals[i] = 32'(i + 2000);
      begin_inf();
      set_vals();
      done_vec = '1;
      tick();
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      bad_cycles = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (out_if.class_tvalid || !busy) bad_cycles++;
      end
      check("t6a_abort_bad_cycles", 64'(bad_cycles), 64'(0));
      done_vec = '0;
      tick();
      for (int i = 0; i < N; i++) vals[i] = 32'(50 - i);
      set_vals();
      expect_result(4'd0, 32'd50, "t6a");
      done_vec = '1;
      tick();
      wait_result("t6a");
      tick();
      done_vec = '0;

      // 6b: reset mid-COLLECT
      begin_inf();
      done_vec = 10'h00F;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6b_tvalid", 64'(out_if.class_tvalid), 64'(0));
      check("t6b_class",  64'(out_if.class_tdata),  64'(0));
      check("t6b_max",    64'(out_if.max_tdata),    64'(0));
      check("t6b_busy",   64'(busy),                64'(0));
      done_vec = '0;
      tick();

      // 6c: start_e coincident with the output handshake
      for (int i = 0; i < N; i++) vals[i] = 32'(i * 7);
      expect_result(4'd9, 32'd63, "t6c");
      out_if.class_tready = 1'b0;
      begin_inf();
      set_vals();
      done_vec = '1;
      tick();
      wait_result("t6c");
      tick();
      out_if.class_tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6c_tvalid_after", 64'(out_if.class_tvalid), 64'(0));
      check("t6c_busy_collect", 64'(busy),                64'(1));
      done_vec = '0;
      tick();
      for (int i = 0; i < N; i++) vals[i] = 32'(1000 - i);
      set_vals();
      expect_result(4'd0, 32'd1000, "t6c2");
      done_vec = '1;
      tick();
      wait_result("t6c2");
      tick();
      done_vec = '0;
      repeat (3) tick();

      check("transfer_count", 64'(pops), 64'(pushes));
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
